// File: rtl/systolic_gemm_engine.sv
// Output-stationary ROWS x COLS signed MAC array with an operand skew stage and a job FSM that
// loads K operand beats, flushes the wavefront and drains C one row per beat.
module systolic_gemm_engine #(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned KLEN_W = 8,
  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [KLEN_W-1:0]       k_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*DATA_W-1:0]  a_data,
  input  logic [COLS*DATA_W-1:0]  b_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_data,
  output logic [RowW-1:0]         out_row,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned FlushW = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

  state_e              state_q, state_d;
  logic [KLEN_W-1:0]   klen_q, klen_d, beat_q, beat_d;
  logic [FlushW-1:0]   flush_q, flush_d;
  logic [RowW-1:0]     row_q, row_d;
  logic                in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                accept, acc_clr;

  assign accept = in_valid & in_ready_q;

  // Operands as they arrive at the left column / top row, already skewed.
  logic [DATA_W-1:0] a_edge  [ROWS];
  logic              av_edge [ROWS];
  logic [DATA_W-1:0] b_edge  [COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    if (r == 0) begin : g_direct
      assign a_edge[r]  = a_data[r*DATA_W +: DATA_W];
      assign av_edge[r] = accept;
    end else begin : g_dly
      logic [DATA_W-1:0] dat_q [r];
      logic [DATA_W-1:0] dat_d [r];
      logic              vld_q [r];
      logic              vld_d [r];
      always_comb begin
        dat_d[0] = a_data[r*DATA_W +: DATA_W];
        vld_d[0] = accept;
        for (int j = 1; j < r; j++) begin
          dat_d[j] = dat_q[j-1];
          vld_d[j] = vld_q[j-1];
        end
      end
      always_ff @(posedge clk) begin
        if (reset) begin
          dat_q <= '{default: '0};
          vld_q <= '{default: 1'b0};
        end else begin
          dat_q <= dat_d;
          vld_q <= vld_d;
        end
      end
      assign a_edge[r]  = dat_q[r-1];
      assign av_edge[r] = vld_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    if (c == 0) begin : g_direct
      assign b_edge[c] = b_data[c*DATA_W +: DATA_W];
    end else begin : g_dly
      logic [DATA_W-1:0] dat_q [c];
      logic [DATA_W-1:0] dat_d [c];
      always_comb begin
        dat_d[0] = b_data[c*DATA_W +: DATA_W];
        for (int j = 1; j < c; j++) dat_d[j] = dat_q[j-1];
      end
      always_ff @(posedge clk) begin
        if (reset) dat_q <= '{default: '0};
        else       dat_q <= dat_d;
      end
      assign b_edge[c] = dat_q[c-1];
    end
  end

  // PE grid: A travels right with its valid bit, B travels down.
  logic [DATA_W-1:0] a_pe  [ROWS][COLS];
  logic              av_pe [ROWS][COLS];
  logic [DATA_W-1:0] b_pe  [ROWS][COLS];
  logic [DATA_W-1:0] a_q   [ROWS][COLS-1];
  logic [DATA_W-1:0] a_d   [ROWS][COLS-1];
  logic              av_q  [ROWS][COLS-1];
  logic              av_d  [ROWS][COLS-1];
  logic [DATA_W-1:0] b_q   [ROWS-1][COLS];
  logic [DATA_W-1:0] b_d   [ROWS-1][COLS];
  logic [ACC_W-1:0]  acc_q [ROWS][COLS];
  logic [ACC_W-1:0]  acc_d [ROWS][COLS];
  logic signed [2*DATA_W-1:0] prod;

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      a_pe[r][0]  = a_edge[r];
      av_pe[r][0] = av_edge[r];
      for (int c = 1; c < COLS; c++) begin
        a_pe[r][c]  = a_q[r][c-1];
        av_pe[r][c] = av_q[r][c-1];
      end
    end
    for (int c = 0; c < COLS; c++) begin
      b_pe[0][c] = b_edge[c];
      for (int r = 1; r < ROWS; r++) b_pe[r][c] = b_q[r-1][c];
    end
  end

  always_comb begin
    prod = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS - 1; c++) begin
        a_d[r][c]  = a_pe[r][c];
        av_d[r][c] = av_pe[r][c];
      end
    end
    for (int r = 0; r < ROWS - 1; r++) begin
      for (int c = 0; c < COLS; c++) b_d[r][c] = b_pe[r][c];
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        prod = $signed(a_pe[r][c]) * $signed(b_pe[r][c]);
        if (acc_clr)          acc_d[r][c] = '0;
        else if (av_pe[r][c]) acc_d[r][c] = acc_q[r][c] + ACC_W'(prod);
        else                  acc_d[r][c] = acc_q[r][c];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    klen_d      = klen_q;
    beat_d      = beat_q;
    flush_d     = flush_q;
    row_d       = row_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    acc_clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          klen_d  = k_len;
          beat_d  = '0;
          row_d   = '0;
          acc_clr = 1'b1;
          busy_d  = 1'b1;
          if (k_len == '0) begin
            state_d     = StDrain;
            out_valid_d = 1'b1;
          end else begin
            state_d    = StLoad;
            in_ready_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          if (beat_q == klen_q - KLEN_W'(1)) begin
            state_d    = StFlush;
            in_ready_d = 1'b0;
            flush_d    = '0;
          end else begin
            beat_d = beat_q + KLEN_W'(1);
          end
        end
      end
      StFlush: begin
        // Wait for the last beat to reach PE(ROWS-1, COLS-1).
        if (flush_q == FlushW'(ROWS + COLS - 2)) begin
          state_d     = StDrain;
          out_valid_d = 1'b1;
        end else begin
          flush_d = flush_q + FlushW'(1);
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (row_q == RowW'(ROWS - 1)) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            row_d       = '0;
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      klen_q      <= '0;
      beat_q      <= '0;
      flush_q     <= '0;
      row_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      a_q         <= '{default: '0};
      av_q        <= '{default: 1'b0};
      b_q         <= '{default: '0};
      acc_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      klen_q      <= klen_d;
      beat_q      <= beat_d;
      flush_q     <= flush_d;
      row_q       <= row_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      a_q         <= a_d;
      av_q        <= av_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
    end
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < COLS; c++) out_data[c*ACC_W +: ACC_W] = acc_q[row_q][c];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_row   = row_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_gemm_engine.sv
// Bench for systolic_gemm_engine: directed and random GEMM jobs checked against a plain
// matrix-multiply reference computed in the bench.
module tb_systolic_gemm_engine;

  localparam int ROWS = 4, COLS = 4, DATA_W = 16, ACC_W = 32, KLEN_W = 8, KMAX = 16, RW = 2;

  logic                   clk = 1'b0;
  logic                   reset, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [KLEN_W-1:0]      k_len;
  logic [ROWS*DATA_W-1:0] a_data;
  logic [COLS*DATA_W-1:0] b_data;
  logic [COLS*ACC_W-1:0]  out_data;
  logic [RW-1:0]          out_row;

  systolic_gemm_engine #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .KLEN_W(KLEN_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, done_cnt = 0, hs_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  logic [DATA_W-1:0] a_m [ROWS][KMAX];
  logic [DATA_W-1:0] b_m [KMAX][COLS];
  logic [ACC_W-1:0]  c_m [ROWS][COLS];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // C = A*B with 64-bit sums, kept modulo 2^ACC_W.
  function automatic void model(input int k);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        longint s = 0;
        for (int i = 0; i < k; i++)
          s += longint'($signed(a_m[r][i])) * longint'($signed(b_m[i][c]));
        c_m[r][c] = s[ACC_W-1:0];
      end
    end
  endfunction

  function automatic void load_identity();
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < ROWS; r++) a_m[r][i] = (r == i) ? 16'd1 : 16'd0;
      for (int c = 0; c < COLS; c++) b_m[i][c] = DATA_W'(4 * i + c + 1);
    end
  endfunction

  function automatic void load_const(input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv);
    for (int i = 0; i < KMAX; i++) begin
      for (int r = 0; r < ROWS; r++) a_m[r][i] = av;
      for (int c = 0; c < COLS; c++) b_m[i][c] = bv;
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_data"}, out_data, 0);
    check_eq({tag, "_out_row"}, out_row, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  task automatic drive_beat(input int idx, input bit v);
    in_valid = v;
    for (int r = 0; r < ROWS; r++)
      a_data[r*DATA_W +: DATA_W] = v ? a_m[r][idx] : DATA_W'($urandom);
    for (int c = 0; c < COLS; c++)
      b_data[c*DATA_W +: DATA_W] = v ? b_m[idx][c] : DATA_W'($urandom);
  endtask

  task automatic do_start(input int k);
    start = 1'b1;
    k_len = KLEN_W'(k);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("start_busy", busy, 1);
    if (k > 0) check_eq("start_in_ready", in_ready, 1);
    else       check_eq("k0_out_valid", out_valid, 1);
  endtask

  // mode 0: continuous, 1: every other cycle, 2: random bubbles.
  task automatic feed(input int k, input int mode, input bit poke_start, output int last_acc);
    int idx = 0;
    int guard = 0;
    bit tog = 1'b0;
    bit hs;
    last_acc = -1;
    while (idx < k && guard < 1000) begin
      bit v;
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      drive_beat(idx, v);
      start = poke_start && (idx == 1);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      if (hs) begin
        idx++;
        last_acc = cyc;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    check_eq("beats_accepted", idx, k);
    check_eq("in_ready_drop", in_ready, 0);
  endtask

  // bp 0: always ready, 1: 5-cycle stall on row 1, 2: random ready.
  task automatic drain(input int bp, input int last_acc);
    int row = 0;
    int guard = 0;
    int stall = 0;
    int hs0 = hs_cnt;
    int d0 = done_cnt;
    bit hs;
    while (!out_valid && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (last_acc >= 0) check_eq("first_valid_latency", cyc - last_acc, ROWS + COLS - 1);
    while (row < ROWS && guard < 400) begin
      case (bp)
        0:       out_ready = 1'b1;
        1:       begin
          out_ready = !(out_row == 1 && stall < 5);
          if (!out_ready) stall++;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      check_eq("out_valid", out_valid, 1);
      check_eq("out_row", out_row, row);
      for (int c = 0; c < COLS; c++)
        check_eq("out_data", out_data[c*ACC_W +: ACC_W], c_m[row][c]);
      hs = out_valid && out_ready;
      @(posedge clk); #1;
      guard++;
      if (hs) row++;
    end
    out_ready = 1'b0;
    check_eq("rows_drained", row, ROWS);
    check_eq("done_high", done, 1);
    check_eq("out_valid_low", out_valid, 0);
    check_eq("busy_low", busy, 0);
    @(posedge clk); #1;
    check_eq("done_low", done, 0);
    check_eq("done_pulses", done_cnt - d0, 1);
    check_eq("handshakes", hs_cnt - hs0, ROWS);
    if (bp == 1) check_eq("stall_cycles", stall, 5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int la;
    reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a_data = '0; b_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("reset");

    load_identity(); model(4);
    do_start(4); feed(4, 0, 1'b0, la); drain(0, la);

    do_start(4); feed(4, 1, 1'b0, la); drain(0, la);

    load_const(16'hFFFF, 16'h8000); model(1);
    do_start(1); feed(1, 0, 1'b0, la); drain(0, la);

    load_const(16'h8000, 16'h8000); model(3);
    do_start(3); feed(3, 0, 1'b0, la); drain(0, la);

    load_identity(); model(4);
    do_start(4); feed(4, 0, 1'b0, la); drain(1, la);

    model(0);
    do_start(0); drain(0, -1);

    model(4);
    do_start(4); feed(4, 0, 1'b1, la); drain(0, la);

    do_start(4);
    for (int i = 0; i < 2; i++) begin
      drive_beat(i, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("midload_reset");
    do_start(4); feed(4, 0, 1'b0, la); drain(0, la);

    for (int t = 0; t < 6; t++) begin
      int k = $urandom_range(1, 12);
      for (int i = 0; i < k; i++) begin
        for (int r = 0; r < ROWS; r++) a_m[r][i] = DATA_W'($urandom);
        for (int c = 0; c < COLS; c++) b_m[i][c] = DATA_W'($urandom);
      end
      model(k);
      do_start(k); feed(k, 2, 1'b0, la); drain(2, la);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_gemm_engine.md
Name: systolic_gemm_engine

Overview:
- Parametrised output-stationary ROWS x COLS signed MAC array with its own job controller.
- Computes C = A·B over a programmable inner dimension K (C is ROWS x COLS, A is ROWS x K, B is K x COLS).
- Skews the input operands internally, tolerates input bubbles, and drains results one row per beat over a valid/ready stream.
- Sits between the operand fetch streams and the result writeback path.

Parameters:
- ROWS, 4, rows of PEs = rows of A and C.
- COLS, 4, columns of PEs = columns of B and C.
- DATA_W, 16, signed operand width.
- ACC_W, 32, signed accumulator width.
- KLEN_W, 8, width of k_len.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  KLEN_W  inner dimension K (unsigned); sampled with start.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine accepts an operand beat.
- a_data  in  ROWS*DATA_W  column k of A; lane r at [r*DATA_W +: DATA_W].
- b_data  in  COLS*DATA_W  row k of B; lane c at [c*DATA_W +: DATA_W].
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts the result row.
- out_data  out  COLS*ACC_W  C[out_row][c] at [c*ACC_W +: ACC_W].
- out_row  out  max(1,clog2(ROWS))  index of the row currently presented.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset: one clk edge with reset=1 returns the engine to IDLE.
  - Cleared: all accumulators, skew and PE pipeline registers, and counters.
  - Output values: in_ready=0, out_valid=0, out_data=0, out_row=0, busy=0, done=0.
  - Reset applies in any state, including mid-job; the partial job is discarded.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - start=1: latch k_len, clear all accumulators, then go to LOAD, or to DRAIN directly if k_len=0.
  - in_valid is ignored.
- LOAD:
  - in_ready=1.
  - A beat is accepted on an edge where in_valid&in_ready.
  - After the k_len-th accepted beat, go to FLUSH; in_ready drops the next cycle.
- Skew and timing:
  - Lane r of A is delayed r cycles; lane c of B is delayed c cycles.
  - A values move right one PE per cycle; B values move down one PE per cycle.
  - A per-element valid bit travels with each A value.
  - A beat accepted at edge e reaches PE(r,c) at edge e+r+c, where acc[r][c] += a*b.
  - No accumulate occurs on bubble slots (valid=0), so gaps in in_valid do not change the result.
- Arithmetic:
  - Signed DATA_W x DATA_W product, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; no saturation.
- FLUSH:
  - in_ready=0.
  - Lasts so that out_valid first rises exactly ROWS+COLS-1 cycles after the edge that accepted the last beat (7 cycles at 4x4).
- DRAIN:
  - out_valid=1, out_row starts at 0, out_data = acc row out_row.
  - On out_valid&out_ready, out_row increments.
  - While out_ready=0, out_data and out_row are held stable.
  - After the handshake with out_row=ROWS-1: out_valid=0, go to IDLE, and done=1 for that first IDLE cycle.
  - A start in that same cycle is accepted.
- k_len=0: the cycle after start, enter DRAIN and present all-zero rows.
- start while busy=1 is ignored.
- Accumulators hold their values after done until the next accepted start.

Test Plan:
- Identity, ROWS=COLS=4:
  - Stimulus: A=I4, B row k = {4k+1..4k+4}, k_len=4, in_valid held high.
  - Response: out rows equal B rows in order; first out_valid 7 cycles after the 4th accepting edge; done pulses once.
- Bubbles: same data, in_valid asserted every other cycle → identical out_data to the identity case.
- Signed and wrap:
  - a=0xFFFF, b=0x8000, k_len=1 → every C = 32768.
  - a=b=0x8000, k_len=3 → every C = 0xC0000000.
- Backpressure: identity job with out_ready=0 for 5 cycles while out_row=1 → out_row and out_data stable; exactly 4 handshakes; single done.
- k_len=0 plus start while busy:
  - k_len=0 → 4 all-zero rows, then done.
  - start pulsed during LOAD → no effect on the running job.
- Reset mid-LOAD: reset after 2 beats → all outputs at reset values next cycle; a fresh identity job then produces correct results.
